mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Control FSM for the multicycle MIPS datapath; drives the ALU's alu_ctrl_sig and consumes its zero flag.
//  Sequences fetch/decode/execute/memory/writeback per instruction, decodes funct for R-type ALU ops,
//  and stalls on memory handshake. Sits in cpu/ beside datapath; sole source of all datapath enables/muxes.
// PARAMETERS
//  MEM_HANDSHAKE  1  1: FETCH/MEMRD/MEMWR wait for mem_ready; 0: mem_ready ignored (treated as 1)
// PORTS
//  clk           in   1  single clock, all state on rising edge
//  rst_n         in   1  asynchronous, active-low reset
//  op            in   6  instr[31:26]
//  funct         in   6  instr[5:0]
//  zero          in   1  ALU zero flag (alu_out == 0)
//  mem_ready     in   1  memory access completes this cycle
//  mem_req       out  1  memory access requested (FETCH, MEMRD, MEMWR)
//  mem_write     out  1  memory write strobe (MEMWR && ready)
//  ir_write      out  1  load instruction register
//  iord          out  1  0: addr=PC, 1: addr=ALUOut
//  reg_dst       out  1  0: rt, 1: rd
//  mem_to_reg    out  1  0: ALUOut, 1: Data reg
//  reg_write     out  1  register file write enable
//  alu_src_a     out  1  0: PC, 1: A
//  alu_src_b     out  2  00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
//  pc_src        out  2  00 ALUResult, 01 ALUOut, 10 jump target
//  pc_en         out  1  PC write enable
//  alu_ctrl_sig  out  3  ALU op: 000 AND,001 OR,010 ADD,110 SUB,111 SLT (011/100/101 never driven)
//  illegal_op    out  1  one-cycle pulse in DECODE for unknown op/funct
// BEHAVIOUR
//  States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX.
//  Reset (rst_n=0): state<=FETCH immediately; while low all enables (mem_req, mem_write, ir_write,
//   reg_write, pc_en) forced 0, illegal_op 0, muxes at FETCH values, alu_ctrl_sig=010.
//  Outputs are Moore from state except pc_en, ir_write, mem_write (also gated by mem_ready/zero).
//  FETCH: mem_req, iord=0, src_a=0, src_b=01, ADD, pc_src=00; ir_write=pc_en=ready; ->DECODE when ready.
//  DECODE: src_a=0, src_b=11, ADD (branch target). Dispatch on op:
//   100011/101011 ->MEMADR; 000000 ->RTYPEEX; 000100 ->BEQEX; 001000 ->ADDIEX; 000010 ->JEX;
//   other op, or R-type funct not in {100000,100010,100100,100101,101010}: illegal_op=1, ->FETCH.
//  MEMADR: src_a=1, src_b=10, ADD; ->MEMRD if op=lw else MEMWR.
//  MEMRD: mem_req, iord=1; ->MEMWB when ready. MEMWB: reg_dst=0, mem_to_reg=1, reg_write; ->FETCH.
//  MEMWR: mem_req, iord=1, mem_write=ready; ->FETCH when ready.
//  RTYPEEX: src_a=1, src_b=00, alu_ctrl from funct: 100000 010, 100010 110, 100100 000,
//   100101 001, 101010 111; ->RTYPEWB. RTYPEWB: reg_dst=1, mem_to_reg=0, reg_write; ->FETCH.
//  BEQEX: src_a=1, src_b=00, SUB, pc_src=01, pc_en=zero (same cycle); ->FETCH.
//  ADDIEX: src_a=1, src_b=10, ADD; ->ADDIWB. ADDIWB: reg_dst=0, mem_to_reg=0, reg_write; ->FETCH.
//  JEX: pc_src=10, pc_en=1; ->FETCH.
//  CPI: lw 5, sw 4, R/addi 4, beq 3, j 3 (zero wait); each mem_ready=0 cycle adds one stall cycle,
//   state and all outputs held stable during stall; no enable fires while stalled.
//  MEM_HANDSHAKE=0: mem_ready internally tied 1.
//  Reset asserted mid-instruction: aborts; no partial write (reg_write/mem_write/pc_en low at once).
//  alu_ctrl_sig never X; default (non-ALU states) 010. illegal_op only ever in DECODE.
// TESTING
//  add (op 000000,funct 100000), ready=1 -> states F,D,RX,RWB; RX alu_ctrl=010; reg_write only in RWB.
//  beq zero=1 then zero=0 -> BEQEX alu_ctrl=110, pc_src=01; pc_en 1 then 0; both 3 cycles.
//  lw with mem_ready low 2 cycles in FETCH and 1 in MEMRD -> 8 cycles total, ir_write once, no early enables.
//  sw -> mem_write=1 exactly one cycle, iord=1, reg_write never 1.
//  op=111111 and R-type funct 000000 -> illegal_op 1 pulse in DECODE, next state FETCH, no writes.
//  rst_n low in MEMWB -> reg_write drops asynchronously, state FETCH, alu_ctrl=010 on release.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM
// Drives every datapath enable and mux select and stalls on the memory handshake.
module mips_multicycle_ctrl #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       ir_write,
  output logic       iord,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic [2:0] alu_ctrl_sig,
  output logic       illegal_op
);

  localparam logic [3:0] FETCH   = 4'd0;
  localparam logic [3:0] DECODE  = 4'd1;
  localparam logic [3:0] MEMADR  = 4'd2;
  localparam logic [3:0] MEMRD   = 4'd3;
  localparam logic [3:0] MEMWB   = 4'd4;
  localparam logic [3:0] MEMWR   = 4'd5;
  localparam logic [3:0] RTYPEEX = 4'd6;
  localparam logic [3:0] RTYPEWB = 4'd7;
  localparam logic [3:0] BEQEX   = 4'd8;
  localparam logic [3:0] ADDIEX  = 4'd9;
  localparam logic [3:0] ADDIWB  = 4'd10;
  localparam logic [3:0] JEX     = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] state;
  logic [3:0] next_state;
  logic       ready;
  logic       funct_ok;
  logic [2:0] funct_alu;

  assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:   next_state = ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = funct_ok ? RTYPEEX : FETCH;
          OP_BEQ:       next_state = BEQEX;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JEX;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR:  next_state = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   next_state = ready ? MEMWB : MEMRD;
      MEMWR:   next_state = ready ? FETCH : MEMWR;
      RTYPEEX: next_state = RTYPEWB;
      ADDIEX:  next_state = ADDIWB;
      default: next_state = FETCH;
    endcase
  end

  // Moore decode; only pc_en, ir_write and mem_write also look at ready/zero.
  always_comb begin
    mem_req      = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    iord         = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write    = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b01;
    pc_src       = 2'b00;
    pc_en        = 1'b0;
    alu_ctrl_sig = ALU_ADD;
    illegal_op   = 1'b0;
    case (state)
      FETCH: begin
        mem_req  = 1'b1;
        ir_write = ready;
        pc_en    = ready;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
          OP_RTYPE: illegal_op = ~funct_ok;
          default:  illegal_op = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEMWR: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = ready;
      end
      RTYPEEX: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b00;
        alu_ctrl_sig = funct_alu;
      end
      RTYPEWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      BEQEX: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b00;
        alu_ctrl_sig = ALU_SUB;
        pc_src       = 2'b01;
        pc_en        = zero;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDIWB: reg_write = 1'b1;
      JEX: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
    // Reset must kill any in-flight write combinationally, not on the next edge.
    if (!rst_n) begin
      mem_req      = 1'b0;
      mem_write    = 1'b0;
      ir_write     = 1'b0;
      iord         = 1'b0;
      reg_dst      = 1'b0;
      mem_to_reg   = 1'b0;
      reg_write    = 1'b0;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'b01;
      pc_src       = 2'b00;
      pc_en        = 1'b0;
      alu_ctrl_sig = ALU_ADD;
      illegal_op   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - table-driven bench for mips_multicycle_ctrl
// Per-cycle vectors name the expected state; corner cases are hand-written sequences.
module tb_mips_multicycle_ctrl;

  localparam int S_RST = 0, S_F = 1, S_D = 2, S_MA = 3, S_MR = 4, S_MWB = 5, S_MW = 6;
  localparam int S_RX = 7, S_RWB = 8, S_BQ = 9, S_AX = 10, S_AWB = 11, S_J = 12;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       ir_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic [2:0] alu;
    logic       illegal;
  } outs_t;

  typedef struct {
    logic       rn;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       ready;
    int         st;
    logic [2:0] alu;
    logic       ill;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, zero, mem_ready;
  logic [5:0] op, funct;

  logic mem_req, mem_write, ir_write, iord, reg_dst, mem_to_reg, reg_write, alu_src_a, pc_en, illegal_op;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl_sig;

  logic h_mem_req, h_mem_write, h_ir_write, h_iord, h_reg_dst, h_mem_to_reg, h_reg_write;
  logic h_alu_src_a, h_pc_en, h_illegal_op;
  logic [1:0] h_alu_src_b, h_pc_src;
  logic [2:0] h_alu_ctrl_sig;

  outs_t outs;
  int pass_cnt = 0;
  int total_cnt = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .ir_write(ir_write), .iord(iord),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_en(pc_en), .alu_ctrl_sig(alu_ctrl_sig),
    .illegal_op(illegal_op)
  );

  mips_multicycle_ctrl #(.MEM_HANDSHAKE(1'b0)) dut_nohs (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(h_mem_req), .mem_write(h_mem_write), .ir_write(h_ir_write), .iord(h_iord),
    .reg_dst(h_reg_dst), .mem_to_reg(h_mem_to_reg), .reg_write(h_reg_write),
    .alu_src_a(h_alu_src_a), .alu_src_b(h_alu_src_b), .pc_src(h_pc_src), .pc_en(h_pc_en),
    .alu_ctrl_sig(h_alu_ctrl_sig), .illegal_op(h_illegal_op)
  );

  assign outs = {mem_req, mem_write, ir_write, iord, reg_dst, mem_to_reg, reg_write, alu_src_a,
                 alu_src_b, pc_src, pc_en, alu_ctrl_sig, illegal_op};

  function automatic vec_t mk(input logic rn, input logic [5:0] o, input logic [5:0] f,
                              input logic z, input logic r, input int st,
                              input logic [2:0] a, input logic ill);
    vec_t v;
    v.rn = rn; v.op = o; v.funct = f; v.zero = z; v.ready = r; v.st = st; v.alu = a; v.ill = ill;
    return v;
  endfunction

  // Expected outputs per state; mask marks the fields that state defines.
  function automatic void expect_for(input vec_t v, output outs_t e, output outs_t m);
    e = '0;
    m = '0;
    m.mem_req = 1'b1; m.mem_write = 1'b1; m.ir_write = 1'b1; m.reg_write = 1'b1;
    m.pc_en = 1'b1; m.alu = 3'b111; m.illegal = 1'b1;
    e.alu = 3'b010;
    case (v.st)
      S_RST: begin
        m.iord = 1'b1; m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; m.pc_src = 2'b11;
        e.alu_src_b = 2'b01;
      end
      S_F: begin
        m.iord = 1'b1; m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; m.pc_src = 2'b11;
        e.mem_req = 1'b1; e.ir_write = v.ready; e.pc_en = v.ready; e.alu_src_b = 2'b01;
      end
      S_D: begin
        m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; e.alu_src_b = 2'b11; e.illegal = v.ill;
      end
      S_MA, S_AX: begin
        m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
      end
      S_MR: begin
        m.iord = 1'b1; e.mem_req = 1'b1; e.iord = 1'b1;
      end
      S_MWB: begin
        m.reg_dst = 1'b1; m.mem_to_reg = 1'b1; e.mem_to_reg = 1'b1; e.reg_write = 1'b1;
      end
      S_MW: begin
        m.iord = 1'b1; e.mem_req = 1'b1; e.iord = 1'b1; e.mem_write = v.ready;
      end
      S_RX: begin
        m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; e.alu_src_a = 1'b1; e.alu = v.alu;
      end
      S_RWB: begin
        m.reg_dst = 1'b1; m.mem_to_reg = 1'b1; e.reg_dst = 1'b1; e.reg_write = 1'b1;
      end
      S_BQ: begin
        m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; m.pc_src = 2'b11;
        e.alu_src_a = 1'b1; e.alu = 3'b110; e.pc_src = 2'b01; e.pc_en = v.zero;
      end
      S_AWB: begin
        m.reg_dst = 1'b1; m.mem_to_reg = 1'b1; e.reg_write = 1'b1;
      end
      S_J: begin
        m.pc_src = 2'b11; e.pc_src = 2'b10; e.pc_en = 1'b1;
      end
      default: ;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  task automatic apply(input vec_t v, input int idx);
    outs_t e, m;
    rst_n = v.rn; op = v.op; funct = v.funct; zero = v.zero; mem_ready = v.ready;
    @(negedge clk);
    expect_for(v, e, m);
    total_cnt++;
    if ((outs & m) === (e & m)) pass_cnt++;
    else $display("FAIL vec%0d st%0d: got %h want %h mask %h", idx, v.st, outs & m, e & m, m);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] rf[5];
    logic [2:0] ra[5];
    rf[0] = 6'b100000; ra[0] = 3'b010;
    rf[1] = 6'b100010; ra[1] = 3'b110;
    rf[2] = 6'b100100; ra[2] = 3'b000;
    rf[3] = 6'b100101; ra[3] = 3'b001;
    rf[4] = 6'b101010; ra[4] = 3'b111;

    tbl.push_back(mk(0, OP_R, 6'b100000, 0, 1, S_RST, 3'b010, 0));
    for (int i = 0; i < 5; i++) begin
      tbl.push_back(mk(1, OP_R, rf[i], 0, 1, S_F,   3'b010, 0));
      tbl.push_back(mk(1, OP_R, rf[i], 0, 1, S_D,   3'b010, 0));
      tbl.push_back(mk(1, OP_R, rf[i], 0, 1, S_RX,  ra[i],  0));
      tbl.push_back(mk(1, OP_R, rf[i], 0, 1, S_RWB, 3'b010, 0));
    end
    for (int z = 1; z >= 0; z--) begin
      tbl.push_back(mk(1, OP_BEQ, 6'd0, z[0], 1, S_F,  3'b010, 0));
      tbl.push_back(mk(1, OP_BEQ, 6'd0, z[0], 1, S_D,  3'b010, 0));
      tbl.push_back(mk(1, OP_BEQ, 6'd0, z[0], 1, S_BQ, 3'b110, 0));
    end
    // lw: two FETCH stalls and one MEMRD stall -> 8 cycles
    tbl.push_back(mk(1, OP_LW, 6'd0, 0, 0, S_F,   3'b010, 0));
    tbl.push_back(mk(1, OP_LW, 6'd0, 0, 0, S_F,   3'b010, 0));
    tbl.push_back(mk(1, OP_LW, 6'd0, 0, 1, S_F,   3'b010, 0));
    tbl.push_back(mk(1, OP_LW, 6'd0, 0, 1, S_D,   3'b010, 0));
    tbl.push_back(mk(1, OP_LW, 6'd0, 0, 1, S_MA,  3'b010, 0));
    tbl.push_back(mk(1, OP_LW, 6'd0, 0, 0, S_MR,  3'b010, 0));
    tbl.push_back(mk(1, OP_LW, 6'd0, 0, 1, S_MR,  3'b010, 0));
    tbl.push_back(mk(1, OP_LW, 6'd0, 0, 1, S_MWB, 3'b010, 0));
    tbl.push_back(mk(1, OP_SW, 6'd0, 0, 1, S_F,   3'b010, 0));
    tbl.push_back(mk(1, OP_SW, 6'd0, 0, 1, S_D,   3'b010, 0));
    tbl.push_back(mk(1, OP_SW, 6'd0, 0, 1, S_MA,  3'b010, 0));
    tbl.push_back(mk(1, OP_SW, 6'd0, 0, 0, S_MW,  3'b010, 0));
    tbl.push_back(mk(1, OP_SW, 6'd0, 0, 1, S_MW,  3'b010, 0));
    tbl.push_back(mk(1, OP_ADDI, 6'd0, 0, 1, S_F,   3'b010, 0));
    tbl.push_back(mk(1, OP_ADDI, 6'd0, 0, 1, S_D,   3'b010, 0));
    tbl.push_back(mk(1, OP_ADDI, 6'd0, 0, 1, S_AX,  3'b010, 0));
    tbl.push_back(mk(1, OP_ADDI, 6'd0, 0, 1, S_AWB, 3'b010, 0));
    tbl.push_back(mk(1, OP_J, 6'd0, 0, 1, S_F, 3'b010, 0));
    tbl.push_back(mk(1, OP_J, 6'd0, 0, 1, S_D, 3'b010, 0));
    tbl.push_back(mk(1, OP_J, 6'd0, 0, 1, S_J, 3'b010, 0));
    tbl.push_back(mk(1, 6'b111111, 6'd0, 0, 1, S_F, 3'b010, 0));
    tbl.push_back(mk(1, 6'b111111, 6'd0, 0, 1, S_D, 3'b010, 1));
    tbl.push_back(mk(1, OP_R, 6'b000000, 0, 1, S_F, 3'b010, 0));
    tbl.push_back(mk(1, OP_R, 6'b000000, 0, 1, S_D, 3'b010, 1));
    tbl.push_back(mk(1, OP_R, 6'b000000, 0, 1, S_F, 3'b010, 0));

    rst_n = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk);
    #1;
    foreach (tbl[i]) apply(tbl[i], i);

    // asynchronous reset while in MEMWB: the register write must drop at once
    apply(mk(1, OP_LW, 6'd0, 0, 1, S_D,  3'b010, 0), 100);
    apply(mk(1, OP_LW, 6'd0, 0, 1, S_MA, 3'b010, 0), 101);
    apply(mk(1, OP_LW, 6'd0, 0, 1, S_MR, 3'b010, 0), 102);
    #2;
    check("memwb_reg_write", 32'(reg_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_reg_write", 32'(reg_write), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_alu", 32'(alu_ctrl_sig), 32'b010);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("rel_alu", 32'(alu_ctrl_sig), 32'b010);
    check("rel_fetch_mem_req", 32'(mem_req), 32'd1);
    check("rel_fetch_iord", 32'(iord), 32'd0);
    @(posedge clk);
    #1;
    apply(mk(1, OP_LW, 6'd0, 0, 1, S_D, 3'b010, 0), 103);

    // handshake disabled: mem_ready is ignored
    rst_n = 1'b0;
    #2;
    check("nohs_rst_mem_req", 32'(h_mem_req), 32'd0);
    rst_n = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    check("hs_fetch_ir_write", 32'(ir_write), 32'd0);
    check("nohs_fetch_ir_write", 32'(h_ir_write), 32'd1);
    check("nohs_fetch_pc_en", 32'(h_pc_en), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("hs_stalled_mem_req", 32'(mem_req), 32'd1);
    check("nohs_decode_mem_req", 32'(h_mem_req), 32'd0);
    check("nohs_decode_src_b", 32'(h_alu_src_b), 32'b11);
    mem_ready = 1'b1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
